// File: rtl/cmplx_pkg.sv
// cmplx_pkg: default widths, pipeline depth and intermediate-width helpers for cmplx_mult_pipe
package cmplx_pkg;
   localparam int CMULT_DW   = 16;
   localparam int CMULT_TW   = 16;
   localparam int CMULT_OW   = 16;
   localparam int CMULT_TAGW = 8;
   localparam int CMULT_LAT  = 4;
   function automatic int prod_w(input int dw, input int tw);
      return dw + tw + 1;
   endfunction
   function automatic int sum_w(input int dw, input int tw);
      return dw + tw + 2;
   endfunction
endpackage

// File: rtl/cmplx_round_sat.sv
// cmplx_round_sat: round half up, arithmetic shift, then saturate (CMULT_SAT_EN) or wrap to OW bits
module cmplx_round_sat #(
   parameter int IW   = 34,
   parameter int OW   = 16,
   parameter int FRAC = 15
)(
   input  logic signed [IW-1:0] x,
   output logic signed [OW-1:0] y,
   output logic                 ovf
);
   localparam logic signed [IW:0] HALF = (IW+1)'(1) << (FRAC-1);
   logic signed [IW:0] r;
   assign r   = ((IW+1)'(x) + HALF) >>> FRAC;
   assign ovf = ~(&r[IW:OW-1] | ~|r[IW:OW-1]);
`ifdef CMULT_SAT_EN
   assign y = ovf ? (r[IW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : r[OW-1:0];
`else
   assign y = r[OW-1:0];
`endif
endmodule

// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: 4-stage complex multiplier y = a*b or a*conj(b); CMULT_SAT_EN enables saturation and sat_flag
module cmplx_mult_pipe import cmplx_pkg::*; #(
   parameter int DW   = CMULT_DW,
   parameter int TW   = CMULT_TW,
   parameter int OW   = CMULT_OW,
   parameter int FRAC = TW - 1,
   parameter int TAGW = CMULT_TAGW
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [DW-1:0]   a_re,
   input  logic signed [DW-1:0]   a_im,
   input  logic signed [TW-1:0]   b_re,
   input  logic signed [TW-1:0]   b_im,
   input  logic                   conj_b,
   input  logic [TAGW-1:0]        in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [OW-1:0]   y_re,
   output logic signed [OW-1:0]   y_im,
   output logic [TAGW-1:0]        out_tag,
   output logic                   sat_flag
);
   localparam int PW = prod_w(DW, TW);
   localparam int SW = sum_w(DW, TW);
   logic                 en;
   logic                 v1, v2, v3;
   logic [TAGW-1:0]      t1, t2, t3;
   logic signed [DW-1:0] a1_re, a1_im;
   logic signed [TW:0]   b1_re, b1_im;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [SW-1:0] s_re, s_im;
   logic signed [OW-1:0] r_re, r_im;
   logic                 ovf_re, ovf_im;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;
   // b is widened by one bit so negating the most negative twiddle stays exact
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         out_valid <= 1'b0;
         t1 <= '0;
         t2 <= '0;
         t3 <= '0;
         out_tag <= '0;
         a1_re <= '0;
         a1_im <= '0;
         b1_re <= '0;
         b1_im <= '0;
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
         s_re <= '0;
         s_im <= '0;
         y_re <= '0;
         y_im <= '0;
      end else if (en) begin
         v1 <= in_valid;
         t1 <= in_tag;
         a1_re <= a_re;
         a1_im <= a_im;
         b1_re <= (TW+1)'(b_re);
         b1_im <= conj_b ? -(TW+1)'(b_im) : (TW+1)'(b_im);
         v2 <= v1;
         t2 <= t1;
         p_rr <= PW'(a1_re) * PW'(b1_re);
         p_ii <= PW'(a1_im) * PW'(b1_im);
         p_ri <= PW'(a1_re) * PW'(b1_im);
         p_ir <= PW'(a1_im) * PW'(b1_re);
         v3 <= v2;
         t3 <= t2;
         s_re <= SW'(p_rr) - SW'(p_ii);
         s_im <= SW'(p_ri) + SW'(p_ir);
         out_valid <= v3;
         out_tag <= t3;
         y_re <= r_re;
         y_im <= r_im;
      end
   end
   cmplx_round_sat #(.IW(SW), .OW(OW), .FRAC(FRAC)) u_rs_re (.x(s_re), .y(r_re), .ovf(ovf_re));
   cmplx_round_sat #(.IW(SW), .OW(OW), .FRAC(FRAC)) u_rs_im (.x(s_im), .y(r_im), .ovf(ovf_im));
`ifdef CMULT_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_flag <= 1'b0;
      else if (en && v3 && (ovf_re || ovf_im)) sat_flag <= 1'b1;
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf_re ^ ovf_im;
   assign sat_flag   = 1'b0;
`endif
endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// tb_cmplx_mult_pipe: directed and randomized checks of cmplx_mult_pipe against an arithmetic reference model
module tb_cmplx_mult_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, conj_b = 1'b0, out_valid, out_ready = 1'b1, sat_flag;
   logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, y_re, y_im;
   logic [7:0] in_tag = '0, out_tag;
   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
      logic [7:0]         tag;
      logic               ov;
   } exp_t;
   exp_t q[$];
   int n_assert = 0, n_fail = 0, cyc = 0, n_out = 0, first_out = -1, last_out = -1;
   logic sat_acc = 1'b0;

   cmplx_mult_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .conj_b(conj_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im),
      .out_tag(out_tag), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic signed [63:0] obs, input logic signed [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", nm, obs, expv);
      end
   endtask

   function automatic void fix(input longint x, output logic signed [15:0] y, output logic ov);
      longint r;
      r  = (x + 16384) >>> 15;
      ov = (r > 32767) || (r < -32768);
`ifdef CMULT_SAT_EN
      y = ov ? ((r < 0) ? -16'sd32768 : 16'sd32767) : 16'(r);
`else
      y = 16'(r);
`endif
   endfunction

   function automatic exp_t model(input logic signed [15:0] ar, ai, br, bi, input logic cj, input logic [7:0] tg);
      exp_t e;
      longint bi2, re, im;
      logic o1, o2;
      bi2 = cj ? -longint'(bi) : longint'(bi);
      re  = longint'(ar) * longint'(br) - longint'(ai) * bi2;
      im  = longint'(ar) * bi2 + longint'(ai) * longint'(br);
      fix(re, e.re, o1);
      fix(im, e.im, o2);
      e.tag = tg;
      e.ov  = o1 | o2;
      return e;
   endfunction

   task automatic cycle(output bit acc);
      #1;
      if (out_valid) begin
         if (q.size() == 0) chk("stale_out", out_valid, 0);
         else begin
            chk("y_re", y_re, q[0].re);
            chk("y_im", y_im, q[0].im);
            chk("out_tag", out_tag, q[0].tag);
            if (out_ready) begin
               sat_acc = sat_acc | q[0].ov;
`ifdef CMULT_SAT_EN
               chk("sat_flag", sat_flag, sat_acc);
`else
               chk("sat_flag", sat_flag, 0);
`endif
               if (first_out < 0) first_out = cyc;
               last_out = cyc;
               n_out++;
               void'(q.pop_front());
            end
         end
      end
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a_re, a_im, b_re, b_im, conj_b, in_tag));
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rand_in(input logic [7:0] tg);
      a_re = 16'($urandom);
      a_im = 16'($urandom);
      b_re = 16'($urandom);
      b_im = 16'($urandom);
      conj_b = 1'($urandom);
      in_tag = tg;
   endtask

   task automatic single(input string nm, input logic signed [15:0] ar, ai, br, bi, input logic cj,
                         input logic signed [15:0] er, ei);
      bit acc;
      int lat;
      a_re = ar; a_im = ai; b_re = br; b_im = bi; conj_b = cj; in_tag = 8'h5A;
      in_valid = 1'b1; out_ready = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         cycle(acc);
         lat++;
      end
      chk({nm, "_lat"}, lat, 4);
      chk({nm, "_re"}, y_re, er);
      chk({nm, "_im"}, y_im, ei);
      cycle(acc);
   endtask

   initial begin
      bit acc;
      int sent, guard, n0, c0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_re", y_re, 0);
      chk("rst_y_im", y_im, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      cycle(acc);

      single("basic", 16384, 0, 16384, 16384, 1'b0, 8192, 8192);
      single("conj1", 0, 16384, 16384, 16384, 1'b1, 8192, 8192);
      single("conj0", 0, 16384, 16384, 16384, 1'b0, -8192, 8192);
`ifdef CMULT_SAT_EN
      single("ovf", -32768, 0, -32768, 0, 1'b0, 32767, 0);
      chk("ovf_sat_flag", sat_flag, 1);
`else
      single("ovf", -32768, 0, -32768, 0, 1'b0, -32768, 0);
      chk("ovf_sat_flag", sat_flag, 0);
`endif

      sent = 0; guard = 0; n0 = n_out;
      rand_in(8'd0);
      while ((sent < 20 || q.size() > 0) && guard < 500) begin
         in_valid  = (sent < 20);
         out_ready = 1'($urandom);
         cycle(acc);
         if (acc) begin
            sent++;
            rand_in(8'(sent));
         end
         guard++;
      end
      chk("bp_delivered", n_out - n0, 20);
      chk("bp_sent", sent, 20);

      in_valid = 1'b0; out_ready = 1'b1;
      cycle(acc);
      n0 = n_out; first_out = -1; c0 = cyc;
      for (int i = 0; i < 32; i++) begin
         rand_in(8'(100 + i));
         in_valid = 1'b1;
         cycle(acc);
      end
      in_valid = 1'b0;
      guard = 0;
      while (q.size() > 0 && guard < 50) begin
         cycle(acc);
         guard++;
      end
      chk("tp_count", n_out - n0, 32);
      chk("tp_fill", first_out - c0, 4);
      chk("tp_span", last_out - first_out, 31);

      for (int i = 0; i < 3; i++) begin
         rand_in(8'(200 + i));
         in_valid = 1'b1;
         cycle(acc);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_y_re", y_re, 0);
      chk("mid_rst_y_im", y_im, 0);
      chk("mid_rst_tag", out_tag, 0);
      chk("mid_rst_sat", sat_flag, 0);
      q.delete();
      sat_acc = 1'b0;
      cycle(acc);
      cycle(acc);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) cycle(acc);
      chk("post_rst_valid", out_valid, 0);
      single("post_rst", 16384, 0, 16384, 16384, 1'b0, 8192, 8192);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
